axis_byte_serializer: RTL and testbench
=======================================

// Module: axis_byte_serializer
// PURPOSE
//  Width-down converter directly upstream of the NPU AXI-Stream input stage: accepts IN_BYTES-wide
//  AXI-Stream words from the DMA, emits one 8-bit beat per kept byte, lowest byte lane first.
//  Carries TLAST to the final kept byte of a TLAST word, holds TUSER (dims/stride/padding/num_channels)
//  stable on every byte of its word, and counts bytes per packet for debug and verification.
// PARAMETERS
//  IN_BYTES    4    upstream word width in bytes (power of 2, >=2)
//  USER_WIDTH  59   tuser width; equals 4*ADDR_WIDTH+NUM_CHANNELS_WIDTH of the input stage (13, 7)
//  CNT_WIDTH   16   width of pkt_bytes counter
// PORTS
//  s_axis_aclk     in   1              clock
//  s_axis_aresetn  in   1              async active-low reset
//  s_axis_tdata    in   8*IN_BYTES     upstream word; byte lane i = bits [8i+7:8i]
//  s_axis_tkeep    in   IN_BYTES       per-lane byte valid
//  s_axis_tvalid   in   1              upstream valid
//  s_axis_tready   out  1              upstream ready
//  s_axis_tlast    in   1              last word of packet
//  s_axis_tuser    in   USER_WIDTH     sideband, per word
//  m_axis_tdata    out  8              serialized byte
//  m_axis_tstrb    out  1              always 1 while m_axis_tvalid
//  m_axis_tvalid   out  1              byte valid
//  m_axis_tready   in   1              downstream ready
//  m_axis_tlast    out  1              last byte of packet
//  m_axis_tuser    out  USER_WIDTH     tuser of the word the current byte came from
//  pkt_bytes       out  CNT_WIDTH      bytes emitted in current packet (incl. current handshake)
//  err_empty_last  out  1              1-cycle pulse: TLAST word with tkeep==0 accepted
// BEHAVIOUR
//  - Reset (async, s_axis_aresetn low): reg word/keep_rem/last/user/pkt_bytes/err = 0; m_axis_tvalid=0,
//    m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, err_empty_last=0; s_axis_tready=1 after reset.
//  - Holding register: data_r, keep_rem (remaining lanes), last_r, user_r. Two states:
//    EMPTY (keep_rem==0): s_axis_tready=1, m_axis_tvalid=0.
//    SERIAL (keep_rem!=0): m_axis_tvalid=1; m_axis_tdata = lane of lowest set bit of keep_rem.
//  - Final byte of word = keep_rem has exactly one bit set. m_axis_tlast = last_r & final byte.
//  - s_axis_tready = EMPTY | (final byte & m_axis_tready)  (combinational; no bubble between words).
//  - Upstream handshake loads data_r<=tdata, keep_rem<=tkeep, last_r<=tlast, user_r<=tuser;
//    first byte appears on m_axis the following cycle (latency 1). Throughput 1 byte/cycle sustained.
//  - Downstream handshake (m_tvalid & m_tready): clear lowest set bit of keep_rem; if final byte and
//    no simultaneous upstream load -> EMPTY.
//  - Sparse tkeep allowed (e.g. 4'b1010 -> lanes 1 then 3); cleared lanes never emitted.
//  - tkeep==0 word: accepted, produces no output, stays EMPTY; if its tlast=1, err_empty_last pulses
//    the next cycle and pkt_bytes clears (packet boundary lost is reported, not repaired).
//  - m_axis_tdata/tuser/tlast stable while m_axis_tvalid & !m_axis_tready (AXIS rule).
//  - pkt_bytes: +1 per downstream handshake; on handshake with m_axis_tlast reload to 0 next cycle.
//    Saturates at all-ones (no wrap).
//  - Upstream tvalid with tready low: nothing captured; tdata may change freely.
//  - Reset mid-word: partial word discarded, no beat emitted after reset release until a new word.
// TESTING
//  1. Word 0x44332211, tkeep=4'hF, tlast=1, m_tready=1 -> bytes 11,22,33,44 on 4 consecutive cycles,
//     tlast only on 44, pkt_bytes 1..4 then 0.
//  2. Two back-to-back full words, tuser=A then B -> 8 contiguous beats, no bubble; tuser=A on beats
//     1-4, B on 5-8; s_tready high exactly on beat 4 cycle.
//  3. tkeep=4'b0011, tdata=0xDDCCBBAA, tlast=1 -> AA then BB(tlast); CC/DD never appear.
//  4. m_tready low 3 cycles during beat 2 of word 0x04030201 -> m_tdata holds 02, s_tready low,
//     sequence resumes 02,03,04 with no loss or duplication.
//  5. tkeep=0, tlast=1 word -> no m_tvalid, err_empty_last 1-cycle pulse, pkt_bytes=0.
//  6. Assert reset after byte 2 of a 4-byte word -> all outputs 0, s_tready=1 after release;
//     next word 0x0000_00EE tkeep=1 tlast=1 -> single beat EE with tlast.

Source files
------------

// File: rtl/axis_byte_serializer.sv
// axis_byte_serializer: AXI-Stream width-down converter emitting one byte per kept lane, lowest lane first
module axis_byte_serializer #(
  parameter int IN_BYTES   = 4,
  parameter int USER_WIDTH = 59,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [8*IN_BYTES-1:0] s_axis_tdata,
  input  logic [IN_BYTES-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tstrb,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  pkt_bytes,
  output logic                  err_empty_last
);
  localparam int LW = $clog2(IN_BYTES);
  logic [8*IN_BYTES-1:0] r_data;
  logic [IN_BYTES-1:0]   r_keep;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_err;
  logic [LW-1:0]         w_idx;
  logic [IN_BYTES-1:0]   w_keep_next;
  logic [CNT_WIDTH-1:0]  w_cnt;
  logic                  w_final;
  logic                  w_m_hs;
  logic                  w_s_hs;
  logic                  w_empty_last;
  // lowest remaining lane picks the byte presented downstream
  always_comb begin
    w_idx = '0;
    for (int i = IN_BYTES - 1; i >= 0; i--)
      if (r_keep[i]) w_idx = LW'(i);
  end
  assign w_keep_next    = r_keep & (r_keep - IN_BYTES'(1));
  assign w_final        = (r_keep != '0) && (w_keep_next == '0);
  assign m_axis_tvalid  = |r_keep;
  assign m_axis_tstrb   = m_axis_tvalid;
  assign m_axis_tdata   = r_data[{w_idx, 3'b000} +: 8];
  assign m_axis_tlast   = r_last & w_final;
  assign m_axis_tuser   = r_user;
  assign s_axis_tready  = ~|r_keep | (w_final & m_axis_tready);
  assign w_m_hs         = m_axis_tvalid & m_axis_tready;
  assign w_s_hs         = s_axis_tvalid & s_axis_tready;
  assign w_empty_last   = w_s_hs & s_axis_tlast & ~|s_axis_tkeep;
  assign w_cnt          = (w_m_hs && r_cnt != '1) ? r_cnt + CNT_WIDTH'(1) : r_cnt;
  assign pkt_bytes      = w_cnt;
  assign err_empty_last = r_err;
  // holding register: load a new word or retire the lowest kept lane
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_user <= '0;
    end else if (w_s_hs) begin
      r_data <= s_axis_tdata;
      r_keep <= s_axis_tkeep;
      r_last <= s_axis_tlast;
      r_user <= s_axis_tuser;
    end else if (w_m_hs) begin
      r_keep <= w_keep_next;
    end
  end
  // packet byte counter and empty-TLAST error pulse
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= ((w_m_hs && m_axis_tlast) || w_empty_last) ? '0 : w_cnt;
      r_err <= w_empty_last;
    end
  end
endmodule

// File: tb/tb_axis_byte_serializer.sv
// tb_axis_byte_serializer: table-driven and directed checks with a byte scoreboard
module tb_axis_byte_serializer;
  localparam int UW = 59;
  localparam int CW = 16;
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   s_tdata = '0;
  logic [3:0]    s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [UW-1:0] s_tuser = '0;
  logic [7:0]    m_tdata;
  logic          m_tstrb;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [CW-1:0] pkt_bytes;
  logic          err;

  always #5 clk = ~clk;

  axis_byte_serializer #(.IN_BYTES(4), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .pkt_bytes(pkt_bytes), .err_empty_last(err)
  );

  typedef struct {
    logic [7:0]    d;
    logic          l;
    logic [UW-1:0] u;
    logic [CW-1:0] n;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [31:0] seq;
    int          n;
  } vec_t;

  beat_t         q[$];
  vec_t          tbl[7];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] mcnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] seq, input int n, input logic l, input logic [UW-1:0] u);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      mcnt   = mcnt + 1'b1;
      b.d    = seq[8*i +: 8];
      b.l    = l && (i == n - 1);
      b.u    = u;
      b.n    = mcnt;
      q.push_back(b);
    end
    if (l) mcnt = '0;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [UW-1:0] u,
                      input logic [31:0] seq, input int n);
    bit ok = 1'b0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = s_tready;
    end
    chk("send_tready", ok, 1);
    if (ok) begin
      @(posedge clk); #1;
      push_word(seq, n, l, u);
    end
    s_tvalid = 1'b0;
    s_tdata  = 32'hDEADBEEF;
    s_tkeep  = 4'hF;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = (q.size() == 0) && !m_tvalid;
    end
    chk("drain", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rstn && m_tvalid && m_tready) begin
        chk("tstrb", m_tstrb, 1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
        end else begin
          beat_t e = q.pop_front();
          chk("tdata", m_tdata, e.d);
          chk("tlast", m_tlast, e.l);
          chk("tuser", m_tuser, e.u);
          chk("pkt_bytes", pkt_bytes, e.n);
        end
      end
    end
  endtask

  initial begin
    logic [UW-1:0] ua;
    logic [UW-1:0] ub;
    tbl[0] = '{d: 32'h44332211, k: 4'hF, l: 1'b1, seq: 32'h44332211, n: 4};
    tbl[1] = '{d: 32'hDDCCBBAA, k: 4'h3, l: 1'b1, seq: 32'h0000BBAA, n: 2};
    tbl[2] = '{d: 32'h87654321, k: 4'hA, l: 1'b0, seq: 32'h00008743, n: 2};
    tbl[3] = '{d: 32'h0A0B0C0D, k: 4'h4, l: 1'b0, seq: 32'h0000000B, n: 1};
    tbl[4] = '{d: 32'h11223344, k: 4'h9, l: 1'b1, seq: 32'h00001144, n: 2};
    tbl[5] = '{d: 32'hCAFEF00D, k: 4'hE, l: 1'b0, seq: 32'h00CAFEF0, n: 3};
    tbl[6] = '{d: 32'h12345678, k: 4'hF, l: 1'b1, seq: 32'h12345678, n: 4};
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_err", err, 0);
    chk("rst_pkt", pkt_bytes, 0);
    chk("rst_tready", s_tready, 1);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tready", s_tready, 1);

    for (int i = 0; i < 7; i++)
      send(tbl[i].d, tbl[i].k, tbl[i].l, UW'({$urandom(), $urandom()}), tbl[i].seq, tbl[i].n);
    drain();
    chk("pkt_after_last", pkt_bytes, 0);

    ua = UW'({$urandom(), $urandom()});
    ub = UW'({$urandom(), $urandom()});
    send(32'hA4A3A2A1, 4'hF, 1'b0, ua, 32'hA4A3A2A1, 4);
    s_tdata = 32'hB4B3B2B1; s_tkeep = 4'hF; s_tlast = 1'b1; s_tuser = ub; s_tvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("b2b_tvalid", m_tvalid, 1);
      if (c < 4) chk("b2b_tready", s_tready, c == 3);
      @(posedge clk); #1;
      if (c == 3) begin
        push_word(32'hB4B3B2B1, 4, 1'b1, ub);
        s_tvalid = 1'b0;
        s_tdata  = 32'hDEADBEEF;
      end
    end
    drain();

    send(32'h04030201, 4'hF, 1'b1, ua, 32'h04030201, 4);
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_tdata", m_tdata, 8'h02);
      chk("stall_tvalid", m_tvalid, 1);
      chk("stall_tready", s_tready, 0);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    drain();

    send(32'h0000BBAA, 4'h3, 1'b0, ub, 32'h0000BBAA, 2);
    drain();
    chk("pkt_open", pkt_bytes, 2);
    send(32'h55555555, 4'h0, 1'b1, ua, 32'h0, 0);
    @(negedge clk);
    chk("empty_err", err, 1);
    chk("empty_tvalid", m_tvalid, 0);
    chk("empty_pkt", pkt_bytes, 0);
    @(negedge clk);
    chk("empty_err_pulse", err, 0);
    chk("empty_tvalid2", m_tvalid, 0);
    @(posedge clk); #1;

    send(32'h04030201, 4'hF, 1'b1, ua, 32'h04030201, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    q.delete();
    mcnt = '0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_tuser", m_tuser, 0);
    chk("mid_rst_pkt", pkt_bytes, 0);
    chk("mid_rst_tready", s_tready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rel_tvalid", m_tvalid, 0);
      chk("rel_tready", s_tready, 1);
    end
    @(posedge clk); #1;
    send(32'h000000EE, 4'h1, 1'b1, ub, 32'h000000EE, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
